// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage: format codes and opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package imm_pkg;

  // Immediate format codes as presented on out_fmt.
  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_NONE = 3'b111;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-to-decode handshake bundle for the immediate-generation stage.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Ports: master = upstream/downstream environment, slave = the stage itself.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode-to-format decode, immediate assembly/sign extension and PC-relative target.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: instr/pc in; imm, fmt, target, illegal out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  localparam bit HAS_OP32 = (RV64_OPS != 0) && (XLEN == 64);

  logic [6:0]  opc;
  logic [31:0] imm32;

  assign opc = instr[6:0];

  always_comb begin
    fmt = FMT_NONE;
    unique case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_OP_IMM32: fmt = HAS_OP32 ? FMT_I : FMT_NONE;
      OPC_STORE:    fmt = FMT_S;
      OPC_BRANCH:   fmt = FMT_B;
      OPC_JAL:      fmt = FMT_J;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      default:      fmt = FMT_NONE;
    endcase
  end

  // All formats take their sign from instr[31]; build the 32-bit form first.
  always_comb begin
    imm32 = 32'd0;
    unique case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'd0};
      default: imm32 = 32'd0;
    endcase
  end

  // Signed size cast widens to XLEN, replicating bit 31 for RV64.
  assign imm = XLEN'($signed(imm32));

  always_comb begin
    target = '0;
    if (fmt == FMT_B || fmt == FMT_J || opc == OPC_AUIPC) begin
      target = pc + imm;
    end else if (opc == OPC_LUI) begin
      target = imm;
    end
  end

  assign illegal = (instr[1:0] != 2'b11) || (fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage between fetch and decode, with a one-entry skid buffer.
// Latency: 1 cycle from accept to out_*; 1 instruction per cycle while out_ready=1.
// Backpressure: in_ready = !skid_valid (registered only); decode stalls fill the skid, never drop.
// Ports: clk, rst_n (async active-low), bus (slave side of imm_gen_stage_if).
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_gen_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_target;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN), .RV64_OPS(RV64_OPS)) u_decode (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .target  (dec_target),
    .illegal (dec_illegal)
  );

  logic            main_valid;
  logic [XLEN-1:0] main_imm;
  logic [2:0]      main_fmt;
  logic [XLEN-1:0] main_target;
  logic            main_illegal;

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic [XLEN-1:0] skid_target;
  logic            skid_illegal;

  logic accept;
  logic main_free;

  assign accept    = bus.in_valid && !skid_valid;
  // Main can take a new entry this edge if it is empty or being consumed.
  assign main_free = !main_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid   <= 1'b0;
      main_imm     <= '0;
      main_fmt     <= FMT_NONE;
      main_target  <= '0;
      main_illegal <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_target  <= '0;
      skid_illegal <= 1'b0;
    end else if (bus.flush) begin
      // Data registers keep stale contents; only the valids matter.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // in_ready is low while skid is held, so no accept competes here.
        main_valid   <= 1'b1;
        main_imm     <= skid_imm;
        main_fmt     <= skid_fmt;
        main_target  <= skid_target;
        main_illegal <= skid_illegal;
        skid_valid   <= 1'b0;
      end else if (accept) begin
        main_valid   <= 1'b1;
        main_imm     <= dec_imm;
        main_fmt     <= dec_fmt;
        main_target  <= dec_target;
        main_illegal <= dec_illegal;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_target  <= dec_target;
      skid_illegal <= dec_illegal;
    end
  end

  assign bus.in_ready    = !skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_imm;
  assign bus.out_fmt     = main_fmt;
  assign bus.out_target  = main_target;
  assign bus.out_illegal = main_illegal;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage between fetch and decode. Derives the immediate format directly from the opcode, so no external select input is needed. Sign-extends the immediate to XLEN and precomputes the PC-relative target. Uses a valid/ready handshake with a one-entry skid buffer, so decode back-pressure never drops an instruction and never creates a combinational ready path.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64; any other value is a fatal elaboration error.
- RV64_OPS, 0: when 1 and XLEN=64, opcodes 0011011 (OP-IMM-32) and 0011011-class I-type are decoded. When 0, they are treated as unknown.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert and active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  000 I, 001 S, 010 B, 011 J, 100 U, 111 none.
- out_target  out  XLEN  PC-relative result (see Operation).
- out_illegal  out  1  in_instr[1:0] != 2'b11, or the opcode is unknown.

## Operation
- Format decode on opcode in_instr[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011, plus 0011011 when RV64_OPS.
  - S: 0100011.
  - B: 1100011.
  - J: 1101111.
  - U: 0110111 (LUI) and 0010111 (AUIPC).
  - Anything else: fmt 111, imm 0, illegal 1.
- Immediate bit layout, before extension to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
- Extension: every format is sign-extended from instr[31] to XLEN. For U-type at XLEN=64, bits 63:32 equal instr[31].
- out_target:
  - B, J and AUIPC: in_pc + imm, modulo 2^XLEN, with wrap-around and no overflow flag.
  - LUI: imm.
  - All other formats: 0.
- Datapath: a main output register plus one skid register.
  - Accept when in_valid && in_ready.
  - If main is empty, or is draining (out_ready=1), the accepted entry goes to main.
  - Otherwise it goes to skid.
  - When main drains and skid is valid, skid moves to main in the same cycle. A new accept then targets skid only if main would still be occupied.
- Flush: at the next edge, main and skid valid both clear and any same-cycle accept is discarded. Data registers hold stale contents, which are don't-care while valid=0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the out_* signals after edge N.
- Throughput is 1 per cycle while out_ready=1.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Reset values: out_valid=0, out_imm=0, out_fmt=111, out_target=0, out_illegal=0, skid_valid=0, and therefore in_ready=1.
- An asserting rst_n mid-transfer discards both entries immediately.
- Stability: while out_valid=1 && out_ready=0, all out_* signals hold constant.
- Simultaneous accept and drain with skid empty: the new entry replaces main and in_ready stays 1.
- Flush has priority over accept, drain and reset release.

## Structure
- imm_pkg holds:
  - fmt constants FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_NONE.
  - Opcode constants OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_OP_IMM32, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC.
- imm_decode: a combinational, XLEN-parametrised sub-module covering opcode-to-fmt, immediate assembly, sign extension, target add and the illegal flag.
- imm_gen_stage contains the handshake, skid buffer and flush logic only.

## Test plan
- XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> after 1 cycle: imm 0xFFFFFFFF, fmt 000, target 0, illegal 0.
- XLEN=32, instr 0xFE000EE3 (beq, imm -4), pc 0x00000000 -> imm 0xFFFFFFFC, fmt 010, target 0xFFFFFFFC (wrap).
- XLEN=64, instr 0x80000537 (lui a0,0x80000) -> imm 0xFFFFFFFF80000000, fmt 100, target equals imm.
- Stream of 4 instructions with out_ready held 0 from cycle 2 -> in_ready drops after the second accept. Outputs are stable and no entry is lost. On release, the entries drain in order, one per cycle.
- Skid full and flush=1 with in_valid=1 in the same cycle -> the next cycle shows out_valid=0 and in_ready=1, and the flushed instruction never appears.
- instr 0x00000000 -> fmt 111, imm 0, illegal 1. Also check that rst_n low mid-stream zeroes out_valid asynchronously, before the next edge.
